// File: rtl/uart_pkg.sv
// Shared UART definitions: framer state encoding, error codes, default header, clogb2.
// UART_FRAMER_CHECKSUM_EN adds the checksum state to the encoding.
package uart_pkg;

`ifdef UART_FRAMER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_HDR = 3'd0,
    S_LEN = 3'd1,
    S_PAY = 3'd2,
    S_CHK = 3'd3,
    S_OUT = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    S_HDR = 3'd0,
    S_LEN = 3'd1,
    S_PAY = 3'd2,
    S_OUT = 3'd4
  } state_e;
`endif

  localparam logic [1:0] ERR_OVERRUN = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CHK     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  // Bits needed to index 'value' entries; never less than one bit.
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_framer_if.sv
// Payload byte stream leaving the framer. Handshake: a byte transfers on every
// rising clk where m_valid_o && m_ready_i; data/last hold while valid is high and ready is low.
interface uart_rx_framer_if;
  logic [7:0] m_data_o;
  logic       m_valid_o;
  logic       m_ready_i;
  logic       m_last_o;

  modport master (output m_data_o, output m_valid_o, output m_last_o, input m_ready_i);
  modport slave  (input m_data_o, input m_valid_o, input m_last_o, output m_ready_i);
endinterface

// File: rtl/uart_frame_buf.sv
// Payload buffer for the framer: c_depth x 8 registers, one write port and an
// asynchronous read port.
module uart_frame_buf #(
  parameter int c_depth = 16,
  parameter int c_aw    = 4
) (
  input  logic            clk,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic [c_aw-1:0] waddr_i,
  input  logic [7:0]      wdata_i,
  input  logic [c_aw-1:0] raddr_i,
  output logic [7:0]      rdata_o
);

  logic [7:0] mem_q [c_depth];
  logic [7:0] mem_d [c_depth];

  always_comb begin
    mem_d = mem_q;
    if (we_i && (int'(waddr_i) < c_depth)) mem_d[waddr_i] = wdata_i;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_o = (int'(raddr_i) < c_depth) ? mem_q[raddr_i] : 8'h00;

endmodule

// File: rtl/uart_rx_framer.sv
// Frame parser behind the UART receiver: header, length, payload [, checksum], then replay.
// Optional feature macro: UART_FRAMER_CHECKSUM_EN (adds checksum byte and S_CHK).
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int         c_clkfreq      = 100_000_000,
  parameter int         c_baudrate     = 115_200,
  parameter int         c_maxlen       = 16,
  parameter logic [7:0] c_header       = HEADER_DEFAULT,
  parameter int         c_timeout_bits = 30
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic [7:0]       din_i,
  input  logic             din_valid_i,
  uart_rx_framer_if.master m_if,
  output logic             frame_ok_o,
  output logic             frame_err_o,
  output logic [1:0]       err_code_o,
  output state_e           state_o
);

  localparam int         IW       = clogb2(c_maxlen);
  localparam int         TO_LIMIT = c_timeout_bits * (c_clkfreq / c_baudrate) - 1;
  localparam int         TW       = clogb2(TO_LIMIT + 1);
  localparam logic [7:0] MAXLEN   = 8'(c_maxlen);
  localparam logic [TW-1:0] TO_MAX = TW'(TO_LIMIT);

  state_e          state_q, state_d;
  logic [7:0]      len_q, len_d;
  logic [IW-1:0]   wr_idx_q, wr_idx_d;
  logic [IW-1:0]   rd_idx_q, rd_idx_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic            frame_ok_q, frame_ok_d;
  logic            frame_err_q, frame_err_d;
  logic [1:0]      err_code_q, err_code_d;
`ifdef UART_FRAMER_CHECKSUM_EN
  logic [7:0]      chk_q, chk_d;
`endif

  logic            buf_we;
  logic [7:0]      rd_data;
  logic            out_valid;
  logic            out_last;
  logic            pay_last;
  logic            timeout_hit;

  uart_frame_buf #(
    .c_depth (c_maxlen),
    .c_aw    (IW)
  ) u_buf (
    .clk     (clk),
    .rst_ni  (rst_ni),
    .we_i    (buf_we),
    .waddr_i (wr_idx_q),
    .wdata_i (din_i),
    .raddr_i (rd_idx_q),
    .rdata_o (rd_data)
  );

  assign out_valid   = (state_q == S_OUT);
  assign out_last    = out_valid && (8'(rd_idx_q) == (len_q - 8'd1));
  assign pay_last    = (8'(wr_idx_q) == (len_q - 8'd1));
  assign timeout_hit = (cnt_q == TO_MAX);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    cnt_d       = '0;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    buf_we      = 1'b0;
`ifdef UART_FRAMER_CHECKSUM_EN
    chk_d       = chk_q;
`endif

    unique case (state_q)
      S_HDR: begin
        if (din_valid_i && (din_i == c_header)) state_d = S_LEN;
      end

      S_LEN: begin
        if (din_valid_i) begin
          len_d = din_i;
`ifdef UART_FRAMER_CHECKSUM_EN
          chk_d = din_i;
`endif
          if ((din_i == 8'd0) || (din_i > MAXLEN)) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = S_HDR;
          end else begin
            wr_idx_d = '0;
            state_d  = S_PAY;
          end
        end else if (timeout_hit) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = S_HDR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_PAY: begin
        if (din_valid_i) begin
          buf_we   = 1'b1;
          wr_idx_d = wr_idx_q + 1'b1;
`ifdef UART_FRAMER_CHECKSUM_EN
          chk_d    = chk_q ^ din_i;
          if (pay_last) state_d = S_CHK;
`else
          if (pay_last) begin
            rd_idx_d   = '0;
            frame_ok_d = 1'b1;
            state_d    = S_OUT;
          end
`endif
        end else if (timeout_hit) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = S_HDR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef UART_FRAMER_CHECKSUM_EN
      S_CHK: begin
        if (din_valid_i) begin
          if (din_i == chk_q) begin
            rd_idx_d   = '0;
            frame_ok_d = 1'b1;
            state_d    = S_OUT;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHK;
            state_d     = S_HDR;
          end
        end else if (timeout_hit) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = S_HDR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif

      S_OUT: begin
        // The buffer is busy replaying; any new byte is lost.
        if (din_valid_i) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_OVERRUN;
        end
        if (m_if.m_ready_i) begin
          if (out_last) state_d = S_HDR;
          else          rd_idx_d = rd_idx_q + 1'b1;
        end
      end

      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_HDR;
      len_q       <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      cnt_q       <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      cnt_q       <= cnt_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

`ifdef UART_FRAMER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) chk_q <= '0;
    else         chk_q <= chk_d;
  end
`endif

  assign m_if.m_valid_o = out_valid;
  assign m_if.m_data_o  = out_valid ? rd_data : 8'h00;
  assign m_if.m_last_o  = out_last;
  assign frame_ok_o     = frame_ok_q;
  assign frame_err_o    = frame_err_q;
  assign err_code_o     = err_code_q;
  assign state_o        = state_q;

endmodule
